operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage that drives the read and write ports of the 32×32 RV32I register file. The register file returns read data one clock after the address is presented and returns the old value when a read and a write to the same register share an edge. This stage issues `Read1`/`Read2` from the incoming instruction and absorbs that one-cycle latency. It forwards in-flight writebacks, forces `x0` to zero, and hands decoded operands downstream over a valid/ready handshake with full throughput.

## Interface
Parameters:
- `XLEN`, 32: data width; matches the register-file data width.
- `AW`, 5: register address width.

Ports (all `XLEN`-wide unless noted):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream instruction valid.
- `in_ready`, output, 1: stage can accept an instruction.
- `in_instr`, input, 32: RV32I instruction; rs1 = [19:15], rs2 = [24:20].
- `in_pc`, input: PC of `in_instr`.
- `Read1`, output, AW: register-file read address, port 1.
- `Read2`, output, AW: register-file read address, port 2.
- `Data1`, input: register-file read data for `Read1`, registered one cycle.
- `Data2`, input: register-file read data for `Read2`, registered one cycle.
- `wb_valid`, input, 1: writeback request this cycle.
- `wb_rd`, input, AW: writeback destination register.
- `wb_data`, input: writeback value.
- `RegWrite`, output, 1: register-file write enable.
- `WriteReg`, output, AW: register-file write address.
- `WriteData`, output: register-file write data.
- `out_valid`, output, 1: operands valid downstream.
- `out_ready`, input, 1: downstream accepts.
- `out_instr`, output, 32: instruction being delivered.
- `out_pc`, output: PC being delivered.
- `out_rs1_val`, output: resolved rs1 operand.
- `out_rs2_val`, output: resolved rs2 operand.

## Operation
- FSM states:
  - EMPTY: no instruction held.
  - RDWAIT: addresses were presented last cycle; `Data1`/`Data2` are current this cycle.
  - HOLD: operands are latched locally because downstream stalled.
- Handshake signals:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
  - `in_ready = (state==EMPTY) | out_fire`.
  - `out_valid = (state != EMPTY)`.
- State transitions:
  - EMPTY: `in_fire` → RDWAIT; otherwise stay in EMPTY.
  - RDWAIT: `out_fire & in_fire` → RDWAIT; `out_fire` alone → EMPTY; `!out_ready` → HOLD.
  - HOLD: `out_fire & in_fire` → RDWAIT; `out_fire` alone → EMPTY; otherwise stay in HOLD.
- Read address selection:
  - On `in_fire`, `Read1`/`Read2` = `in_instr[19:15]`/`[24:20]`.
  - Otherwise they hold the registered rs1/rs2 of the current instruction.
- Accept registers: on `in_fire`, latch instr, pc, rs1 and rs2.
- Write pass-through (combinational):
  - `RegWrite = wb_valid & (wb_rd != 0)`.
  - `WriteReg = wb_rd`, `WriteData = wb_data`.
  - A write to `x0` never reaches the register file.
- Last-write register: records the write committed at each edge (valid, rd, data); cleared at reset.
- Operand resolution in RDWAIT, per source `rs`, first match wins:
  1. `rs == 0` → 0.
  2. Current cycle `wb_valid & wb_rd == rs` → `wb_data`.
  3. Last-write valid and `rd == rs` → last-write data.
  4. Otherwise → `DataN`.
- Operand handling in HOLD:
  - Entering HOLD latches the resolved operands.
  - While in HOLD, a `RegWrite` with matching rd updates the held operand at the edge.
  - Outputs use priority rules 1–2, then the held value.

## Timing
- Latency: `in_fire` at edge N makes `out_valid` high from edge N+1.
- Throughput: one instruction per cycle sustained while `out_ready` is high.
- `out_*` must be stable while `out_valid & !out_ready`, except for forwarding updates to matching operands.
- Reset values, asserted asynchronously while `rst_n` is low:
  - state = EMPTY; `out_valid` = 0; `in_ready` = 1.
  - `Read1`/`Read2` = 0.
  - `out_instr`, `out_pc`, `out_rs1_val`, `out_rs2_val` = 0.
  - `RegWrite` = 0; last-write register cleared.
- Reset mid-operation discards the held instruction; no partial delivery.
- A write and an accept in the same cycle are legal; the write is forwarded via the last-write register.

## Structure
- Shared package `rv32i_pkg` holds:
  - `XLEN`, `REG_AW`.
  - Field constants `RS1_LSB`/`RS1_MSB`, `RS2_LSB`/`RS2_MSB`.
  - `of_state_e` enum {`OF_EMPTY`, `OF_RDWAIT`, `OF_HOLD`}.
- Sub-module `operand_bypass`: combinational priority mux for one source, instantiated twice.

## Test plan
- Plain read: preload x5 = 0x11, x6 = 0x22; send `add x7,x5,x6` with `out_ready` = 1 → next cycle `out_valid` = 1, rs1 = 0x11, rs2 = 0x22.
- Same-edge hazard: writeback x5 = 0xAA in the same cycle the instruction is accepted → `out_rs1_val` = 0xAA, not the stale 0x11.
- Same-cycle forward: instruction in RDWAIT with `wb_valid`, rd = 6, data 0xBB → `out_rs2_val` = 0xBB combinationally.
- Stall: hold `out_ready` = 0 for 3 cycles and write x5 = 0xCC during the stall → outputs stay stable except rs1, which becomes 0xCC; `in_ready` = 0 throughout.
- `x0`: writeback rd = 0, data 0xFF → `RegWrite` = 0; an instruction reading x0 gets operand 0.
- Back-to-back stream of 4 instructions plus `rst_n` pulsed low mid-stream → 1 per cycle before the reset; after reset all outputs are 0, `in_ready` = 1, and the stream resumes cleanly.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths, register-field positions and
// the operand-fetch state encoding.
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS2_MSB = 24;

    typedef enum logic [1:0] {
        OF_EMPTY,
        OF_RDWAIT,
        OF_HOLD
    } of_state_e;

endpackage

// File: rtl/operand_bypass.sv
// Priority mux resolving one source operand: x0, current writeback,
// previous-edge writeback, then the supplied base value.
module operand_bypass #(
    parameter int unsigned XLEN = rv32i_pkg::XLEN,
    parameter int unsigned AW   = rv32i_pkg::REG_AW
) (
    input  logic [AW-1:0]   rs,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            lw_en,
    input  logic            lw_valid,
    input  logic [AW-1:0]   lw_rd,
    input  logic [XLEN-1:0] lw_data,
    input  logic [XLEN-1:0] base,
    output logic [XLEN-1:0] val
);

    always_comb begin
        if (rs == '0) begin
            val = '0;
        end else if (wb_valid && (wb_rd == rs)) begin
            val = wb_data;
        end else if (lw_en && lw_valid && (lw_rd == rs)) begin
            // Register file returned the pre-write value on that edge.
            val = lw_data;
        end else begin
            val = base;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: issues register-file reads, absorbs the one-cycle read
// latency, forwards writebacks and delivers operands over valid/ready.
module operand_fetch #(
    parameter int unsigned XLEN = rv32i_pkg::XLEN,
    parameter int unsigned AW   = rv32i_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [AW-1:0]   Read1,
    output logic [AW-1:0]   Read2,
    input  logic [XLEN-1:0] Data1,
    input  logic [XLEN-1:0] Data2,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            RegWrite,
    output logic [AW-1:0]   WriteReg,
    output logic [XLEN-1:0] WriteData,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val
);

    import rv32i_pkg::*;

    of_state_e       state_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic [XLEN-1:0] held1_q;
    logic [XLEN-1:0] held2_q;
    logic            lw_valid_q;
    logic [AW-1:0]   lw_rd_q;
    logic [XLEN-1:0] lw_data_q;

    logic            in_fire;
    logic            out_fire;
    logic            rdwait;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [XLEN-1:0] base1;
    logic [XLEN-1:0] base2;
    logic [XLEN-1:0] res1;
    logic [XLEN-1:0] res2;

    assign in_rs1 = AW'(in_instr[RS1_MSB:RS1_LSB]);
    assign in_rs2 = AW'(in_instr[RS2_MSB:RS2_LSB]);

    assign out_valid = (state_q != OF_EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = (state_q == OF_EMPTY) | out_fire;
    assign in_fire   = in_valid & in_ready;
    assign rdwait    = (state_q == OF_RDWAIT);

    assign Read1 = in_fire ? in_rs1 : rs1_q;
    assign Read2 = in_fire ? in_rs2 : rs2_q;

    assign RegWrite  = wb_valid & (wb_rd != '0);
    assign WriteReg  = wb_rd;
    assign WriteData = wb_data;

    assign base1 = rdwait ? Data1 : held1_q;
    assign base2 = rdwait ? Data2 : held2_q;

    operand_bypass #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_bypass_rs1 (
        .rs       (rs1_q),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .lw_en    (rdwait),
        .lw_valid (lw_valid_q),
        .lw_rd    (lw_rd_q),
        .lw_data  (lw_data_q),
        .base     (base1),
        .val      (res1)
    );

    operand_bypass #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_bypass_rs2 (
        .rs       (rs2_q),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .lw_en    (rdwait),
        .lw_valid (lw_valid_q),
        .lw_rd    (lw_rd_q),
        .lw_data  (lw_data_q),
        .base     (base2),
        .val      (res2)
    );

    assign out_instr   = instr_q;
    assign out_pc      = pc_q;
    assign out_rs1_val = out_valid ? res1 : '0;
    assign out_rs2_val = out_valid ? res2 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OF_EMPTY;
            instr_q    <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            held1_q    <= '0;
            held2_q    <= '0;
            lw_valid_q <= 1'b0;
            lw_rd_q    <= '0;
            lw_data_q  <= '0;
        end else begin
            lw_valid_q <= RegWrite;
            lw_rd_q    <= wb_rd;
            lw_data_q  <= wb_data;

            if (in_fire) begin
                instr_q <= in_instr;
                pc_q    <= in_pc;
                rs1_q   <= in_rs1;
                rs2_q   <= in_rs2;
            end

            unique case (state_q)
                OF_EMPTY: begin
                    if (in_fire) state_q <= OF_RDWAIT;
                end
                OF_RDWAIT, OF_HOLD: begin
                    if (out_fire) begin
                        state_q <= in_fire ? OF_RDWAIT : OF_EMPTY;
                    end else begin
                        // Resolved value already folds in this cycle's matching write.
                        state_q <= OF_HOLD;
                        held1_q <= res1;
                        held2_q <= res2;
                    end
                end
                default: state_q <= OF_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed hazard scenarios followed by
// randomized traffic, judged against an architectural register-state model.
module tb_operand_fetch;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [AW-1:0]   Read1;
    logic [AW-1:0]   Read2;
    logic [XLEN-1:0] Data1;
    logic [XLEN-1:0] Data2;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            RegWrite;
    logic [AW-1:0]   WriteReg;
    logic [XLEN-1:0] WriteData;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;

    operand_fetch #(
        .XLEN (XLEN),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .Read1       (Read1),
        .Read2       (Read2),
        .Data1       (Data1),
        .Data2       (Data2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val)
    );

    always #5 clk = ~clk;

    // Register file: synchronous read, old value on a same-edge write.
    logic [XLEN-1:0] rf [32];
    always @(posedge clk) begin
        if (RegWrite) rf[WriteReg] <= WriteData;
        Data1 <= rf[Read1];
        Data2 <= rf[Read2];
    end

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } txn_t;

    txn_t            pend[$];
    logic [XLEN-1:0] arch [32];
    int              n_checks = 0;
    int              n_pass = 0;

    localparam logic [31:0] ADD_X7_X5_X6 = 32'h0062_83B3;
    localparam logic [31:0] ADD_X1_X0_X0 = 32'h0000_00B3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Architectural value of rs as seen this cycle, including the write in flight.
    function automatic logic [XLEN-1:0] exp_opnd(input logic [AW-1:0] rs);
        if (rs == '0) return '0;
        if (wb_valid && wb_rd == rs) return wb_data;
        return arch[rs];
    endfunction

    task automatic cycle_checks();
        bit   exp_valid;
        bit   exp_ready;
        bit   exp_we;
        txn_t t;
        exp_valid = (pend.size() != 0);
        exp_ready = !exp_valid || out_ready;
        exp_we    = wb_valid && (wb_rd != '0);
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("reg_write", 32'(RegWrite), 32'(exp_we));
        if (exp_we) begin
            check_eq("write_reg", 32'(WriteReg), 32'(wb_rd));
            check_eq("write_data", WriteData, wb_data);
        end
        if (exp_valid) begin
            t = pend[0];
            check_eq("out_instr", out_instr, t.instr);
            check_eq("out_pc", out_pc, t.pc);
            check_eq("rs1_val", out_rs1_val, exp_opnd(t.instr[19:15]));
            check_eq("rs2_val", out_rs2_val, exp_opnd(t.instr[24:20]));
        end
        if (exp_we) arch[wb_rd] = wb_data;
        if (exp_valid && out_ready) void'(pend.pop_front());
        if (in_valid && exp_ready) begin
            t.instr = in_instr;
            t.pc    = in_pc;
            pend.push_back(t);
        end
    endtask

    task automatic finish_cycle();
        cycle_checks();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        wb_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        check_eq("rst_read1", 32'(Read1), 32'h0);
        check_eq("rst_read2", 32'(Read2), 32'h0);
        check_eq("rst_out_instr", out_instr, 32'h0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_rs1_val", out_rs1_val, 32'h0);
        check_eq("rst_rs2_val", out_rs2_val, 32'h0);
        check_eq("rst_reg_write", 32'(RegWrite), 32'h0);
        pend.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ins;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Preload every register through the write port.
        for (int r = 1; r < 32; r++) begin
            wb_valid = 1'b1;
            wb_rd    = AW'(r);
            wb_data  = (r == 5) ? 32'h11 : (r == 6) ? 32'h22 : $urandom;
            tick();
        end
        wb_valid = 1'b0;

        // Plain read.
        in_valid = 1'b1; in_instr = ADD_X7_X5_X6; in_pc = 32'h100;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("plain_valid", 32'(out_valid), 32'h1);
        check_eq("plain_rs1", out_rs1_val, 32'h11);
        check_eq("plain_rs2", out_rs2_val, 32'h22);
        finish_cycle();

        // Writeback on the accept edge: register file returns the stale value.
        in_valid = 1'b1; in_pc = 32'h104;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
        tick();
        in_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check_eq("hazard_rs1", out_rs1_val, 32'hAA);
        check_eq("hazard_rs2", out_rs2_val, 32'h22);
        finish_cycle();

        // Same-cycle forward while the read data is arriving.
        in_valid = 1'b1; in_pc = 32'h108;
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'hBB;
        @(negedge clk);
        check_eq("fwd_rs2", out_rs2_val, 32'hBB);
        finish_cycle();
        wb_valid = 1'b0;

        // Downstream stall with a write to rs1 during the stall.
        in_valid = 1'b1; in_pc = 32'h200;
        tick();
        out_ready = 1'b0;
        in_instr = ADD_X1_X0_X0; in_pc = 32'h204;
        for (int c = 0; c < 3; c++) begin
            wb_valid = (c == 0);
            wb_rd = 5'd5; wb_data = 32'hCC;
            @(negedge clk);
            check_eq("stall_in_ready", 32'(in_ready), 32'h0);
            check_eq("stall_instr", out_instr, ADD_X7_X5_X6);
            check_eq("stall_pc", out_pc, 32'h200);
            check_eq("stall_rs1", out_rs1_val, 32'hCC);
            check_eq("stall_rs2", out_rs2_val, 32'hBB);
            finish_cycle();
        end
        wb_valid = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        tick();

        // x0: never written, always reads zero.
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
        in_valid = 1'b1; in_instr = ADD_X1_X0_X0; in_pc = 32'h280;
        @(negedge clk);
        check_eq("x0_reg_write", 32'(RegWrite), 32'h0);
        finish_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("x0_rs1", out_rs1_val, 32'h0);
        check_eq("x0_rs2", out_rs2_val, 32'h0);
        finish_cycle();
        wb_valid = 1'b0;

        // Back-to-back stream with a reset in the middle.
        in_instr = ADD_X7_X5_X6;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) do_reset();
            in_valid = 1'b1;
            in_pc = 32'h300 + 32'(4 * k);
            @(negedge clk);
            if (k != 0 && k != 3) begin
                check_eq("stream_valid", 32'(out_valid), 32'h1);
                check_eq("stream_pc", out_pc, 32'h300 + 32'(4 * (k - 1)));
            end
            finish_cycle();
        end
        in_valid = 1'b0;
        tick();

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[19:15] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) ins[24:20] = 5'($urandom_range(0, 3));
            in_instr  = ins;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_rd     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3))
                                                    : 5'($urandom_range(0, 31));
            wb_data   = $urandom;
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
